// File: rtl/gpio_ctrl_v2.sv
// Memory-mapped GPIO controller: per-pin direction/enable/mask, atomic toggle,
// synchronised inputs and rise/fall edge capture into a W1C status with level irq.
module gpio_ctrl_v2 #(
   parameter int                PIN         = 8,
   parameter int                ADDR_W      = 7,
   parameter logic [ADDR_W-1:0] BASE        = 7'h78,
   parameter int                SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic              wen,
   input  logic [31:0]       wdata,
   output logic [31:0]       rdata,
   input  logic [PIN-1:0]    gpio_in,
   output logic [PIN-1:0]    gpio_out,
   output logic [PIN-1:0]    gpio_oe,
   output logic              irq
);

   localparam logic [2:0] OFF_DIR    = 3'd0;
   localparam logic [2:0] OFF_OUT    = 3'd1;
   localparam logic [2:0] OFF_MASK   = 3'd2;
   localparam logic [2:0] OFF_IN     = 3'd3;
   localparam logic [2:0] OFF_RISE   = 3'd4;
   localparam logic [2:0] OFF_FALL   = 3'd5;
   localparam logic [2:0] OFF_STATUS = 3'd6;
   localparam logic [2:0] OFF_TOGGLE = 3'd7;

   logic                              w_hit;
   logic [2:0]                        w_off;
   logic                              w_we;
   logic [PIN-1:0]                    w_wd;
   logic [PIN-1:0]                    w_sync;
   logic [PIN-1:0]                    w_rise;
   logic [PIN-1:0]                    w_fall;
   logic [PIN-1:0]                    w_clr;
   logic                              w_unused;

   logic [PIN-1:0]                    r_dir;
   logic [PIN-1:0]                    r_out;
   logic [PIN-1:0]                    r_mask;
   logic [PIN-1:0]                    r_rise_en;
   logic [PIN-1:0]                    r_fall_en;
   logic [PIN-1:0]                    r_status;
   logic [PIN-1:0]                    r_prev;
   logic [SYNC_STAGES-1:0][PIN-1:0]   r_sync;

   assign w_hit    = (addr[ADDR_W-1:3] == BASE[ADDR_W-1:3]);
   assign w_off    = addr[2:0];
   assign w_we     = wen & w_hit;
   assign w_wd     = wdata[PIN-1:0];
   // upper data bits are don't-care for narrow configurations
   assign w_unused = ^wdata;

   assign w_sync = r_sync[SYNC_STAGES-1];
   assign w_rise = w_sync & ~r_prev;
   assign w_fall = ~w_sync & r_prev;
   assign w_clr  = (w_we && (w_off == OFF_STATUS)) ? w_wd : '0;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync <= '0;
         r_prev <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], gpio_in};
         r_prev <= w_sync;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_dir     <= '0;
         r_out     <= '0;
         r_mask    <= '0;
         r_rise_en <= '0;
         r_fall_en <= '0;
      end else if (w_we) begin
         case (w_off)
            OFF_DIR:    r_dir     <= w_wd;
            OFF_OUT:    r_out     <= w_wd;
            OFF_MASK:   r_mask    <= w_wd;
            OFF_RISE:   r_rise_en <= w_wd;
            OFF_FALL:   r_fall_en <= w_wd;
            OFF_TOGGLE: r_out     <= r_out ^ w_wd;
            default:    ;
         endcase
      end
   end

   // a fresh edge outranks a simultaneous write-1-to-clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_status <= '0;
      end else begin
         r_status <= (r_status & ~w_clr) | (w_rise & r_rise_en) | (w_fall & r_fall_en);
      end
   end

   always_comb begin
      rdata = '0;
      if (w_hit) begin
         case (w_off)
            OFF_DIR:    rdata[PIN-1:0] = r_dir;
            OFF_OUT:    rdata[PIN-1:0] = r_out;
            OFF_MASK:   rdata[PIN-1:0] = r_mask;
            OFF_IN:     rdata[PIN-1:0] = w_sync;
            OFF_RISE:   rdata[PIN-1:0] = r_rise_en;
            OFF_FALL:   rdata[PIN-1:0] = r_fall_en;
            OFF_STATUS: rdata[PIN-1:0] = r_status;
            default:    rdata          = '0;
         endcase
      end
   end

   assign gpio_oe  = r_dir;
   assign gpio_out = r_out & r_mask & r_dir;
   assign irq      = |r_status;

endmodule
